// File: rtl/insmem_loader_if.sv
// rtl/insmem_loader_if.sv - byte-stream loader handshake bundle for insmem_loader
//
// Purpose: carries the program byte stream from the debug/UART path into
// the instruction memory loader.
// Signals:
//   ld_byte  - program byte (source -> loader)
//   ld_valid - ld_byte is valid (source -> loader)
//   ld_done  - end of program stream (source -> loader)
//   ld_ready - loader accepts a byte this cycle (loader -> source)
// Modports: master = byte source, slave = insmem_loader.
interface insmem_loader_if;
  logic [7:0] ld_byte;
  logic       ld_valid;
  logic       ld_done;
  logic       ld_ready;

  modport master (output ld_byte, output ld_valid, output ld_done, input ld_ready);
  modport slave  (input ld_byte, input ld_valid, input ld_done, output ld_ready);
endinterface

// File: rtl/insmem_loader.sv
// rtl/insmem_loader.sv - byte-addressed instruction memory with stream loader and sweep clear
//
// Purpose: combinational little-endian fetch port for the IF stage; program
// bytes are assembled into words and written word-at-a-time from a base
// address; a CLEAR sweep zeroes the whole memory one word per cycle.
// Optional per-word even parity is enabled by defining INSMEM_PARITY_EN.
// Ports:
//   clk, reset       - clock (rising edge), asynchronous active-high reset
//   fetch_addr       - byte address of the instruction to read
//   instruction      - combinational read, byte k = mem[(fetch_addr+k) mod depth]
//   fetch_misaligned - fetch_addr is not word aligned
//   ld_start/ld_base - start a load at the word-aligned ld_base
//   ld_if            - byte stream (ld_byte/ld_valid/ld_done in, ld_ready out)
//   clr_start        - start a sweep clear of the whole memory
//   busy             - FSM is not IDLE
//   load_count       - bytes accepted in the current/last load (saturating)
//   overflow         - sticky: bytes were discarded past the top of memory
//   parity_err       - aligned fetch word fails even parity (0 without parity)
module insmem_loader #(
  parameter int ADDR_W     = 10,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       fetch_addr,
  output logic [8*WORD_BYTES-1:0] instruction,
  output logic                    fetch_misaligned,
  input  logic                    ld_start,
  input  logic [ADDR_W-1:0]       ld_base,
  insmem_loader_if.slave          ld_if,
  input  logic                    clr_start,
  output logic                    busy,
  output logic [ADDR_W:0]         load_count,
  output logic                    overflow,
  output logic                    parity_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int OFF_W  = $clog2(WORD_BYTES);
  localparam int WIDX_W = ADDR_W - OFF_W;
  localparam int WORDS  = DEPTH / WORD_BYTES;
  localparam int DW     = 8 * WORD_BYTES;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [WIDX_W-1:0] wr_ptr;      // word index; doubles as the CLEAR sweep pointer
  logic [OFF_W-1:0]  byte_idx;
  logic [DW-1:0]     asm_q;
  logic              full;

  logic              ld_ready_c;
  logic              accept;
  logic              last_lane;
  logic [DW-1:0]     asm_ins;     // assembly register with the current byte placed
  logic [OFF_W-1:0]  idx_after;
  logic              mem_we;
  logic [DW-1:0]     mem_wdata;

  // Low base bits are deliberately dropped when aligning the load address.
  logic unused_base_bits;
  assign unused_base_bits = ^ld_base[OFF_W-1:0];

  assign accept    = ld_if.ld_valid & ld_ready_c;
  assign last_lane = (byte_idx == OFF_W'(WORD_BYTES - 1));
  assign ld_if.ld_ready = ld_ready_c;

  always_comb begin
    asm_ins = asm_q;
    asm_ins[8*byte_idx +: 8] = ld_if.ld_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_ready_c = 1'b0;
    busy       = (state_q != IDLE);
    mem_we     = 1'b0;
    mem_wdata  = '0;
    idx_after  = byte_idx;
    case (state_q)
      IDLE: begin
        if (clr_start)     state_d = CLEAR;
        else if (ld_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready_c = 1'b1;
        if (accept) begin
          idx_after = byte_idx + OFF_W'(1);
          if (last_lane && !full) begin
            mem_we    = 1'b1;
            mem_wdata = asm_ins;
          end
        end
        // ld_done sees the lane index after any same-cycle byte.
        if (ld_if.ld_done) state_d = (idx_after != '0) ? FLUSH : IDLE;
      end
      FLUSH: begin
        mem_we    = !full;
        mem_wdata = asm_q;
        state_d   = IDLE;
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (wr_ptr == WIDX_W'(WORDS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      full       <= 1'b0;
      overflow   <= 1'b0;
      load_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            wr_ptr <= '0;
          end else if (ld_start) begin
            wr_ptr     <= ld_base[ADDR_W-1:OFF_W];
            byte_idx   <= '0;
            asm_q      <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            load_count <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (load_count != '1) load_count <= load_count + 1'b1;
            if (full) overflow <= 1'b1;
            byte_idx <= idx_after;
            if (last_lane) begin
              asm_q <= '0;
              // Stop at the top word instead of wrapping into low memory.
              if (!full) begin
                if (wr_ptr == WIDX_W'(WORDS - 1)) full <= 1'b1;
                else                              wr_ptr <= wr_ptr + 1'b1;
              end
            end else begin
              asm_q <= asm_ins;
            end
          end
        end
        FLUSH: begin
          byte_idx <= '0;
          asm_q    <= '0;
        end
        CLEAR: wr_ptr <= wr_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Memory contents survive reset by design.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < WORD_BYTES; k++)
        mem[{wr_ptr, OFF_W'(k)}] <= mem_wdata[8*k +: 8];
    end
  end

  always_comb begin
    instruction = '0;
    for (int k = 0; k < WORD_BYTES; k++)
      instruction[8*k +: 8] = mem[fetch_addr + ADDR_W'(k)];
  end

  assign fetch_misaligned = (fetch_addr[OFF_W-1:0] != '0);

`ifdef INSMEM_PARITY_EN
  logic par_mem [WORDS];

  always_ff @(posedge clk) begin
    if (mem_we) par_mem[wr_ptr] <= ^mem_wdata;
  end

  assign parity_err = !fetch_misaligned && (^instruction ^ par_mem[fetch_addr[ADDR_W-1:OFF_W]]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_insmem_loader.sv
// tb/tb_insmem_loader.sv - directed self-checking bench for insmem_loader
module tb_insmem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // default-size instance (ADDR_W=10)
  logic [9:0]  fetch_addr0 = '0;
  logic [31:0] instruction0;
  logic        misaligned0, busy0, overflow0, parity_err0;
  logic        ld_start0 = 1'b0, clr_start0 = 1'b0;
  logic [9:0]  ld_base0 = '0;
  logic [10:0] load_count0;

  // small instance (ADDR_W=6)
  logic [5:0]  fetch_addr6 = '0;
  logic [31:0] instruction6;
  logic        misaligned6, busy6, overflow6, parity_err6;
  logic        ld_start6 = 1'b0, clr_start6 = 1'b0;
  logic [5:0]  ld_base6 = '0;
  logic [6:0]  load_count6;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  insmem_loader_if lif0 ();
  insmem_loader_if lif6 ();

  insmem_loader dut (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr0), .instruction(instruction0),
    .fetch_misaligned(misaligned0), .ld_start(ld_start0), .ld_base(ld_base0),
    .ld_if(lif0), .clr_start(clr_start0), .busy(busy0), .load_count(load_count0),
    .overflow(overflow0), .parity_err(parity_err0)
  );

  insmem_loader #(.ADDR_W(6), .WORD_BYTES(4)) dut6 (
    .clk(clk), .reset(reset), .fetch_addr(fetch_addr6), .instruction(instruction6),
    .fetch_misaligned(misaligned6), .ld_start(ld_start6), .ld_base(ld_base6),
    .ld_if(lif6), .clr_start(clr_start6), .busy(busy6), .load_count(load_count6),
    .overflow(overflow6), .parity_err(parity_err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [7:0] b, input logic done);
    lif0.ld_byte = b; lif0.ld_valid = 1'b1; lif0.ld_done = done;
    tick();
    lif0.ld_valid = 1'b0; lif0.ld_done = 1'b0;
  endtask

  task automatic send6(input logic [7:0] b);
    lif6.ld_byte = b; lif6.ld_valid = 1'b1;
    tick();
    lif6.ld_valid = 1'b0;
  endtask

  task automatic done0();
    lif0.ld_done = 1'b1; tick(); lif0.ld_done = 1'b0;
  endtask

  task automatic done6();
    lif6.ld_done = 1'b1; tick(); lif6.ld_done = 1'b0;
  endtask

  initial begin
    int cnt;
    logic ready_seen;
    logic [31:0] orv;

    lif0.ld_byte = '0; lif0.ld_valid = 1'b0; lif0.ld_done = 1'b0;
    lif6.ld_byte = '0; lif6.ld_valid = 1'b0; lif6.ld_done = 1'b0;

    // reset state
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ready", 32'(lif0.ld_ready), 32'd0);
    check("rst_count", 32'(load_count0), 32'd0);
    check("rst_overflow", 32'(overflow0), 32'd0);

    // test 1: two words at base 0
    ld_start0 = 1'b1; ld_base0 = 10'h000;
    tick();
    ld_start0 = 1'b0;
    check("t1_ready_load", 32'(lif0.ld_ready), 32'd1);
    check("t1_busy_load", 32'(busy0), 32'd1);
    send0(8'h13, 1'b0); send0(8'h00, 1'b0); send0(8'h00, 1'b0); send0(8'h00, 1'b0);
    send0(8'h93, 1'b0); send0(8'h00, 1'b0); send0(8'h10, 1'b0); send0(8'h00, 1'b0);
    check("t1_busy_before_done", 32'(busy0), 32'd1);
    done0();
    check("t1_busy_after_done", 32'(busy0), 32'd0);
    fetch_addr0 = 10'h000; #1;
    check("t1_word0", instruction0, 32'h00000013);
    fetch_addr0 = 10'h004; #1;
    check("t1_word1", instruction0, 32'h00100093);
    check("t1_aligned", 32'(misaligned0), 32'd0);
    check("t1_count", 32'(load_count0), 32'd8);
    check("t1_overflow", 32'(overflow0), 32'd0);

    // test 2: partial word flush from unaligned base 0x13
    ld_start0 = 1'b1; ld_base0 = 10'h013;
    tick();
    ld_start0 = 1'b0;
    send0(8'hAA, 1'b0); send0(8'hBB, 1'b0); send0(8'hCC, 1'b1);
    check("t2_flush_busy", 32'(busy0), 32'd1);
    check("t2_flush_ready", 32'(lif0.ld_ready), 32'd0);
    tick();
    check("t2_idle_after_flush", 32'(busy0), 32'd0);
    fetch_addr0 = 10'h010; #1;
    check("t2_word", instruction0, 32'h00CCBBAA);
    check("t2_count", 32'(load_count0), 32'd3);
    fetch_addr0 = 10'h012; #1;
    check("t2_misaligned", 32'(misaligned0), 32'd1);
    check("t2_parity_misaligned", 32'(parity_err0), 32'd0);
    fetch_addr0 = 10'h000; #1;
    check("t2_word0_kept", instruction0, 32'h00000013);

    // test 3: small memory, preload word 0 then overflow past the top
    ld_start6 = 1'b1; ld_base6 = 6'h00;
    tick();
    ld_start6 = 1'b0;
    send6(8'hEF); send6(8'hBE); send6(8'hAD); send6(8'hDE);
    done6();
    ld_start6 = 1'b1; ld_base6 = 6'h3C;
    tick();
    ld_start6 = 1'b0;
    for (int i = 1; i <= 8; i++) send6(8'(i));
    done6();
    check("t3_busy", 32'(busy6), 32'd0);
    fetch_addr6 = 6'h3C; #1;
    check("t3_top_word", instruction6, 32'h04030201);
    fetch_addr6 = 6'h00; #1;
    check("t3_word0_kept", instruction6, 32'hDEADBEEF);
    fetch_addr6 = 6'h3E; #1;
    check("t3_wrap_fetch", instruction6, 32'hBEEF0403);
    check("t3_overflow", 32'(overflow6), 32'd1);
    check("t3_count", 32'(load_count6), 32'd8);

    // test 4: clear wins over simultaneous load start
    clr_start0 = 1'b1; ld_start0 = 1'b1; ld_base0 = 10'h100;
    tick();
    clr_start0 = 1'b0; ld_start0 = 1'b0;
    cnt = 0; ready_seen = 1'b0;
    while (busy0 && cnt < 400) begin
      if (lif0.ld_ready) ready_seen = 1'b1;
      lif0.ld_valid = 1'b1;
      cnt++;
      tick();
    end
    lif0.ld_valid = 1'b0;
    check("t4_busy_cycles", 32'(cnt), 32'd256);
    check("t4_ready_low", 32'(ready_seen), 32'd0);
    check("t4_count_untouched", 32'(load_count0), 32'd3);
    orv = '0;
    for (int a = 0; a < 1024; a += 4) begin
      fetch_addr0 = 10'(a); #1;
      orv |= instruction0;
    end
    check("t4_all_zero", orv, 32'h0);

    // test 5: bytes ignored in IDLE, then reset mid-load
    lif0.ld_byte = 8'h55; lif0.ld_valid = 1'b1;
    check("t5_idle_ready", 32'(lif0.ld_ready), 32'd0);
    tick(); tick();
    lif0.ld_valid = 1'b0;
    check("t5_idle_busy", 32'(busy0), 32'd0);
    fetch_addr0 = 10'h000; #1;
    check("t5_idle_no_write", instruction0, 32'h0);
    ld_start0 = 1'b1; ld_base0 = 10'h020;
    tick();
    ld_start0 = 1'b0;
    send0(8'h11, 1'b0); send0(8'h22, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t5_reset_busy", 32'(busy0), 32'd0);
    check("t5_reset_ready", 32'(lif0.ld_ready), 32'd0);
    check("t5_reset_count", 32'(load_count0), 32'd0);
    tick();
    reset = 1'b0;
    fetch_addr0 = 10'h020; #1;
    check("t5_target_unchanged", instruction0, 32'h0);

    // test 6: parity
    ld_start0 = 1'b1; ld_base0 = 10'h000;
    tick();
    ld_start0 = 1'b0;
    send0(8'h01, 1'b0); send0(8'h00, 1'b0); send0(8'h00, 1'b0); send0(8'h00, 1'b0);
    done0();
    fetch_addr0 = 10'h000; #1;
    check("t6_word", instruction0, 32'h00000001);
    check("t6_parity_ok", 32'(parity_err0), 32'd0);
`ifdef INSMEM_PARITY_EN
    dut.mem[0] = 8'h00;
    #1;
    check("t6_parity_flip", 32'(parity_err0), 32'd1);
`else
    fetch_addr0 = 10'h004; #1;
    check("t6_parity_off", 32'(parity_err0), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, observed running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/insmem_loader.md
Name: insmem_loader

Overview:
Parametrised, byte-addressed instruction memory for the IF stage, with a built-in byte-stream loader and a sweep-clear engine.
- Program bytes arrive one at a time from the debug/UART path over a valid/ready handshake. They are assembled little-endian into words and written word-at-a-time from a programmable base address.
- The fetch port stays combinational so the pipeline timing is unchanged.

Parameters:
ADDR_W, 10, byte-address width; memory depth = 2^ADDR_W bytes.
WORD_BYTES, 4, bytes per instruction word; instruction width = 8*WORD_BYTES; power of two, >= 2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
fetch_addr  in  ADDR_W  byte address of the instruction to read.
instruction  out  8*WORD_BYTES  combinational little-endian read; byte k = mem[(fetch_addr+k) mod depth].
fetch_misaligned  out  1  combinational; 1 when fetch_addr[log2(WORD_BYTES)-1:0] != 0.
ld_start  in  1  pulse: begin a load at ld_base.
ld_base  in  ADDR_W  load start address; low log2(WORD_BYTES) bits ignored (forced to 0).
ld_byte  in  8  program byte.
ld_valid  in  1  ld_byte valid.
ld_ready  out  1  loader accepts a byte this cycle.
ld_done  in  1  end of program stream.
clr_start  in  1  pulse: zero the whole memory.
busy  out  1  1 in any state other than IDLE.
load_count  out  ADDR_W+1  bytes accepted in the current/last load, discarded bytes included.
overflow  out  1  sticky; bytes were discarded past the top of memory.
parity_err  out  1  see Optional Feature.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-high.
  - Reset puts the FSM in IDLE and clears ld_ready, busy, overflow, load_count, the write pointer wr_ptr, byte index byte_idx, the assembly register and the full flag.
  - Memory contents are NOT touched by reset; use CLEAR.
- FSM states: IDLE, LOAD, FLUSH, CLEAR.
- IDLE:
  - clr_start -> CLEAR. clr_start has priority over a simultaneous ld_start.
  - ld_start -> LOAD. On entry: wr_ptr <= aligned ld_base, byte_idx <= 0, load_count <= 0, overflow <= 0, full <= 0, assembly register <= 0.
  - ld_valid/ld_done are ignored in IDLE; ld_ready = 0.
- LOAD:
  - ld_ready = 1. A byte is accepted when ld_valid & ld_ready.
  - Accepted byte goes to lane byte_idx; load_count increments, saturating at 2^(ADDR_W+1)-1.
  - When byte_idx == WORD_BYTES-1: the full word, including this byte, is written to mem[wr_ptr .. wr_ptr+WORD_BYTES-1] at that edge. Then wr_ptr += WORD_BYTES, byte_idx <= 0, assembly register <= 0.
  - If that write used the last word of memory, full <= 1.
  - While full, accepted bytes are counted but not written, and overflow <= 1. wr_ptr never wraps into low memory.
  - ld_done: evaluated after the same-cycle byte, if any. If byte_idx is nonzero after that byte -> FLUSH, else -> IDLE.
  - ld_start and clr_start are ignored outside IDLE.
- FLUSH:
  - One cycle. Writes the partial word; unfilled lanes are 0.
  - If full is set, nothing is written.
  - Then -> IDLE. ld_ready = 0.
- CLEAR:
  - Writes 0 to one word per cycle, word 0 upward, for 2^ADDR_W/WORD_BYTES cycles, then -> IDLE.
  - ld_ready = 0.
- Read/write visibility: a word written at edge N appears on instruction from after edge N; there is no bypass of the assembly register.
- Misaligned fetch: data is still returned byte-wise with wrap modulo depth; fetch_misaligned flags it.
- Reset mid-LOAD/FLUSH/CLEAR: immediate return to IDLE. The partially assembled word is lost; words already written are retained.

Optional Feature:
Macro INSMEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per aligned word, computed on every word write; CLEAR writes parity 0.
  - parity_err is combinational: 1 when fetch_addr is aligned and the XOR of the stored word and its parity bit is 1.
- Undefined: no parity storage; parity_err tied to 0.

Test Plan:
1. Reset, then ld_start with ld_base=0x00; stream 13 00 00 00 93 00 10 00; then ld_done -> fetch 0x00 = 0x00000013, fetch 0x04 = 0x00100093, load_count = 8, overflow = 0, busy falls the cycle after ld_done.
2. ld_start with ld_base=0x13 (aligned to 0x10); stream AA BB CC, with ld_done on the CC cycle -> FLUSH for exactly 1 cycle; fetch 0x10 = 0x00CCBBAA; fetch 0x12 reports fetch_misaligned = 1.
3. ADDR_W=6; preload word 0x00 = 0xDEADBEEF; ld_start with base 0x3C; stream 8 bytes 01..08 -> fetch 0x3C = 0x04030201, word 0x00 still 0xDEADBEEF, overflow = 1, load_count = 8.
4. After test 1, clr_start pulsed together with ld_start -> CLEAR wins; busy high exactly 256 cycles (defaults); every aligned fetch then reads 0; ld_ready stays 0 throughout.
5. Assert ld_valid in IDLE -> no write, ld_ready = 0. Then in LOAD accept 2 bytes, assert reset -> FSM in IDLE, ld_ready = 0, target word unchanged, load_count = 0.
6. INSMEM_PARITY_EN defined: load word 0x00000001, then flip stored bit 0 via hierarchical deposit -> fetch 0x00 gives parity_err = 1. Undefined: parity_err stays 0.
